// File: rtl/seq_div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package seq_div_pkg;

    localparam int DIV_N = 5;
    localparam int ITER  = 2 * DIV_N;
    localparam int CNT_W = $clog2(2 * DIV_N + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int N = 5
) (
    input  logic [N:0]   prem_i,
    input  logic         bit_i,
    input  logic [N-1:0] divisor_i,
    output logic [N:0]   prem_o,
    output logic         qbit_o
);

    logic [N:0] shifted;

    // prem_i < divisor always holds, so the shifted value fits in N+1 bits;
    // the compare still uses the full width for the decision.
    assign shifted = {prem_i[N-1:0], bit_i};
    assign qbit_o  = ({prem_i, bit_i} >= {2'b00, divisor_i});
    assign prem_o  = qbit_o ? (shifted - {1'b0, divisor_i}) : shifted;

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor over 2N cycles,
// with the same start/finish handshake as the shift-add multiplier.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           finish,
    output logic           div_by_zero
);

    localparam int STEPS = 2 * N;
    localparam int CW    = $clog2(2 * N + 1);

    div_state_e     state_q;
    logic [2*N-1:0] dvd_q;
    logic [N-1:0]   dsr_q;
    logic [N:0]     prem_q;
    logic [CW-1:0]  cnt_q;

    logic [N:0]     prem_nxt;
    logic           qbit;

    div_step #(.N(N)) u_step (
        .prem_i    (prem_q),
        .bit_i     (dvd_q[2*N-1]),
        .divisor_i (dsr_q),
        .prem_o    (prem_nxt),
        .qbit_o    (qbit)
    );

    // The dividend register doubles as the quotient shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dsr_q       <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            finish      <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvd_q       <= dividend;
                        dsr_q       <= divisor;
                        prem_q      <= '0;
                        cnt_q       <= '0;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend[N-1:0];
                            div_by_zero <= 1'b1;
                            finish      <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    prem_q <= prem_nxt;
                    dvd_q  <= {dvd_q[2*N-2:0], qbit};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(STEPS - 1)) begin
                        quotient  <= {dvd_q[2*N-2:0], qbit};
                        remainder <= prem_nxt[N-1:0];
                        finish    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    finish  <= 1'b0;
                    state_q <= start ? WAIT_LOW : IDLE;
                end
                WAIT_LOW: begin
                    if (!start) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks for seq_divider (N=5).
module tb_seq_divider;

    localparam int N = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [2*N-1:0] dividend = '0;
    logic [N-1:0]   divisor = '0;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           finish;
    logic           div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .finish      (finish),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Stimulus only: launches one operation and reports edges until finish (-1 on timeout).
    task automatic do_op(input logic [2*N-1:0] dd, input logic [N-1:0] ds,
                         input bit hold, output int edges);
        edges    = -1;
        dividend = dd;
        divisor  = ds;
        start    = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (!hold) start = 1'b0;
            if (finish) begin
                edges = e;
                break;
            end
        end
        if (!hold) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({quotient, remainder, finish, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%0d r=%0d fin=%b dbz=%b, want all 0",
                     quotient, remainder, finish, div_by_zero);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_hold();
        int edges;
        int nfin;
        do_op(10'd780, 5'd30, 1'b1, edges);
        checks++;
        if (edges !== 11) begin errors++; $display("FAIL basic_latency: got %0d edges, want 11", edges); end
        checks++;
        if (quotient !== 10'd26) begin errors++; $display("FAIL basic_quot: got %0d, want 26", quotient); end
        checks++;
        if (remainder !== 5'd0) begin errors++; $display("FAIL basic_rem: got %0d, want 0", remainder); end
        checks++;
        if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b, want 0", div_by_zero); end
        nfin = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (finish) nfin++;
        end
        checks++;
        if (nfin !== 0) begin errors++; $display("FAIL no_retrigger: got %0d finish cycles, want 0", nfin); end
        checks++;
        if (quotient !== 10'd26) begin errors++; $display("FAIL hold_quot: got %0d, want 26", quotient); end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_pulse();
        int edges;
        do_op(10'd1000, 5'd31, 1'b0, edges);
        checks++;
        if (edges !== 11) begin errors++; $display("FAIL pulse_latency: got %0d, want 11", edges); end
        checks++;
        if ({quotient, remainder} !== {10'd32, 5'd8}) begin
            errors++; $display("FAIL pulse_1000_31: got q=%0d r=%0d, want q=32 r=8", quotient, remainder);
        end
        do_op(10'd169, 5'd13, 1'b0, edges);
        checks++;
        if ({quotient, remainder} !== {10'd13, 5'd0}) begin
            errors++; $display("FAIL pulse_169_13: got q=%0d r=%0d, want q=13 r=0", quotient, remainder);
        end
    endtask

    task automatic test_boundaries();
        int edges;
        logic [2*N-1:0] dd [3] = '{10'd1023, 10'd5, 10'd0};
        logic [N-1:0]   ds [3] = '{5'd1, 5'd31, 5'd7};
        logic [2*N-1:0] eq [3] = '{10'd1023, 10'd0, 10'd0};
        logic [N-1:0]   er [3] = '{5'd0, 5'd5, 5'd0};
        for (int i = 0; i < 3; i++) begin
            do_op(dd[i], ds[i], 1'b0, edges);
            checks++;
            if ({quotient, remainder} !== {eq[i], er[i]} || edges !== 11) begin
                errors++;
                $display("FAIL boundary_%0d_%0d: got q=%0d r=%0d edges=%0d, want q=%0d r=%0d edges=11",
                         dd[i], ds[i], quotient, remainder, edges, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int edges;
        do_op(10'd500, 5'd0, 1'b0, edges);
        checks++;
        if (edges !== 1) begin errors++; $display("FAIL dbz_latency: got %0d, want 1", edges); end
        checks++;
        if ({div_by_zero, quotient, remainder} !== {1'b1, 10'd1023, 5'd20}) begin
            errors++;
            $display("FAIL dbz_result: got dbz=%b q=%0d r=%0d, want dbz=1 q=1023 r=20",
                     div_by_zero, quotient, remainder);
        end
        do_op(10'd1000, 5'd31, 1'b0, edges);
        checks++;
        if ({div_by_zero, quotient, remainder} !== {1'b0, 10'd32, 5'd8}) begin
            errors++;
            $display("FAIL dbz_clear: got dbz=%b q=%0d r=%0d, want dbz=0 q=32 r=8",
                     div_by_zero, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_op();
        int edges;
        int nfin;
        dividend = 10'd780;
        divisor  = 5'd30;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({quotient, remainder, finish, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL midop_reset: got q=%0d r=%0d fin=%b dbz=%b, want all 0",
                     quotient, remainder, finish, div_by_zero);
        end
        #10;
        reset = 1'b1;
        nfin = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (finish) nfin++;
        end
        checks++;
        if (nfin !== 0) begin errors++; $display("FAIL midop_idle: got %0d finish cycles, want 0", nfin); end
        do_op(10'd169, 5'd13, 1'b0, edges);
        checks++;
        if ({quotient, remainder} !== {10'd13, 5'd0} || edges !== 11) begin
            errors++;
            $display("FAIL midop_restart: got q=%0d r=%0d edges=%0d, want q=13 r=0 edges=11",
                     quotient, remainder, edges);
        end
    endtask

    task automatic test_busy_inputs();
        int edges;
        dividend = 10'd1000;
        divisor  = 5'd31;
        start    = 1'b1;
        @(posedge clk); #1;
        edges = -1;
        for (int e = 2; e <= 40; e++) begin
            dividend = 10'($urandom);
            divisor  = 5'($urandom);
            start    = ~start;
            @(posedge clk); #1;
            if (finish) begin
                edges = e;
                break;
            end
        end
        checks++;
        if ({quotient, remainder} !== {10'd32, 5'd8} || edges !== 11) begin
            errors++;
            $display("FAIL busy_inputs: got q=%0d r=%0d edges=%0d, want q=32 r=8 edges=11",
                     quotient, remainder, edges);
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_random_sweep();
        int edges;
        int bad;
        logic [2*N-1:0] dd;
        logic [N-1:0]   ds;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            dd = 10'($urandom);
            ds = 5'($urandom_range(31, 1));
            do_op(dd, ds, 1'b0, edges);
            checks++;
            if (quotient !== 10'(int'(dd) / int'(ds)) || remainder !== 5'(int'(dd) % int'(ds))
                || int'(quotient) * int'(ds) + int'(remainder) != int'(dd)
                || remainder >= ds || edges !== 11) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_%0d_%0d: got q=%0d r=%0d edges=%0d, want q=%0d r=%0d edges=11",
                             dd, ds, quotient, remainder, edges, int'(dd) / int'(ds), int'(dd) % int'(ds));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_hold();
        test_pulse();
        test_boundaries();
        test_div_by_zero();
        test_reset_mid_op();
        test_busy_inputs();
        test_random_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
